blink_meter: RTL and testbench

//   Measures a slow square wave, such as a blink/LED drive, on input sig_in.

---
 rtl/blink_meter_if.sv | 24 ++
 rtl/blink_meter.sv | 147 ++++++++++++++
 tb/tb_blink_meter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/blink_meter_if.sv
// Bundles the blink meter's measured input, clear and measurement results.
// The slave modport is the meter's side; the master modport drives sig_in/clr and observes results.
interface blink_meter_if #(
    parameter int CNT_W = 32
) ();
    logic             sig_in;
    logic             clr;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             ovf;
    logic             match;

    modport master (
        output sig_in, clr,
        input  high_time, low_time, period, meas_valid, ovf, match
    );

    modport slave (
        input  sig_in, clr,
        output high_time, low_time, period, meas_valid, ovf, match
    );
endinterface

// File: rtl/blink_meter.sv
// Measures high/low phase lengths and period of a slow square wave, reporting once per full pair.
// Latency: input edge to meas_valid is SYNC_STAGES+1 cycles; no backpressure. Optional BLINK_METER_CHECK_EN adds match.
module blink_meter #(
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned EXP_HIGH    = 25000000,
    parameter int unsigned EXP_LOW     = 25000000,
    parameter int unsigned TOL         = 1024
) (
    input logic          clk,
    input logic          rst_n,
    blink_meter_if.slave bus
);
    typedef enum logic [1:0] {S_WAIT, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       high_tmp_q, high_tmp_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic [CNT_W-1:0]       low_time_q, low_time_d;
    logic [CNT_W:0]         period_q, period_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   match_q, match_d;

    logic sig_s, edge_ok, rise, fall, cnt_max, sat;

`ifdef BLINK_METER_CHECK_EN
    localparam logic [CNT_W-1:0] EXP_H = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] EXP_L = CNT_W'(EXP_LOW);
    localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);

    function automatic logic within(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] e);
        logic [CNT_W-1:0] d;
        d = (v > e) ? (v - e) : (e - v);
        return d <= TOL_C;
    endfunction
`endif

    // Edges only count once prev_q holds a real sample, so a level present at reset release is a partial phase.
    assign sig_s   = sync_q[SYNC_STAGES-1];
    assign edge_ok = prime_q[SYNC_STAGES];
    assign rise    = edge_ok & sig_s & ~prev_q;
    assign fall    = edge_ok & ~sig_s & prev_q;
    assign cnt_max = &cnt_q;
    assign sat     = cnt_max & ~rise & ~fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prime_q      <= '0;
            prev_q       <= 1'b0;
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            high_tmp_q   <= '0;
            high_time_q  <= '0;
            low_time_q   <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            prime_q      <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            prev_q       <= sig_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            high_tmp_q   <= high_tmp_d;
            high_time_q  <= high_time_d;
            low_time_q   <= low_time_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            ovf_q        <= ovf_d;
            match_q      <= match_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_max ? cnt_q : cnt_q + ONE;
        high_tmp_d   = high_tmp_q;
        high_time_d  = high_time_q;
        low_time_d   = low_time_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        // Saturating while idle in WAIT is not a measurement overflow.
        ovf_d        = ovf_q | (sat & (state_q != S_WAIT));
`ifdef BLINK_METER_CHECK_EN
        match_d      = match_q;
`else
        match_d      = 1'b0;
`endif

        unique case (state_q)
            S_WAIT: begin
                if (rise) begin
                    state_d = S_HIGH;
                    cnt_d   = ONE;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    high_tmp_d = cnt_q;
                    state_d    = S_LOW;
                    cnt_d      = ONE;
                end
            end
            S_LOW: begin
                if (rise) begin
                    high_time_d  = high_tmp_q;
                    low_time_d   = cnt_q;
                    period_d     = {1'b0, high_tmp_q} + {1'b0, cnt_q};
                    meas_valid_d = 1'b1;
                    state_d      = S_HIGH;
                    cnt_d        = ONE;
`ifdef BLINK_METER_CHECK_EN
                    match_d      = within(high_tmp_q, EXP_H) & within(cnt_q, EXP_L) & ~ovf_q;
`endif
                end
            end
            default: state_d = S_WAIT;
        endcase

        if (bus.clr) begin
            state_d      = S_WAIT;
            cnt_d        = '0;
            high_time_d  = '0;
            low_time_d   = '0;
            period_d     = '0;
            meas_valid_d = 1'b0;
            ovf_d        = 1'b0;
            match_d      = 1'b0;
        end
    end

    assign bus.high_time  = high_time_q;
    assign bus.low_time   = low_time_q;
    assign bus.period     = period_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.ovf        = ovf_q;
    assign bus.match      = match_q;
endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter: a 32-bit instance for measurement/reset/check cases,
// and a 4-bit instance for counter saturation and clear.
module tb_blink_meter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   a_mv_cnt;
    int   m0;
    logic exp_match;

    blink_meter_if #(.CNT_W(32)) a_if ();
    blink_meter_if #(.CNT_W(4))  b_if ();

    blink_meter #(.CNT_W(32), .SYNC_STAGES(2), .EXP_HIGH(10), .EXP_LOW(20), .TOL(1)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    blink_meter #(.CNT_W(4), .SYNC_STAGES(2), .EXP_HIGH(10), .EXP_LOW(20), .TOL(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (a_if.meas_valid === 1'b1) a_mv_cnt <= a_mv_cnt + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) a_if.sig_in = v;
        else            b_if.sig_in = v;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        a_mv_cnt = 0;
`ifdef BLINK_METER_CHECK_EN
        exp_match = 1'b1;
`else
        exp_match = 1'b0;
`endif
        rst_n = 1'b0;
        a_if.sig_in = 1'b0; a_if.clr = 1'b0;
        b_if.sig_in = 1'b0; b_if.clr = 1'b0;

        // Reset with a toggling input
        for (int i = 0; i < 6; i++) begin
            a_if.sig_in = ~a_if.sig_in;
            b_if.sig_in = ~b_if.sig_in;
            tick(1);
        end
        check("rst_high_time", a_if.high_time, 0);
        check("rst_low_time",  a_if.low_time, 0);
        check("rst_period",    a_if.period, 0);
        check("rst_ovf",       a_if.ovf, 0);
        check("rst_match",     a_if.match, 0);
        check("rst_no_mv",     a_mv_cnt, 0);
        a_if.sig_in = 1'b0; b_if.sig_in = 1'b0;
        rst_n = 1'b1;

        // Steady wave, start low
        drive(0, 0, 5);
        drive(0, 1, 10);
        drive(0, 0, 20);
        check("idle_before_pair", a_mv_cnt, 0);
        a_if.sig_in = 1'b1;
        tick(2);
        check("latency_not_yet", a_if.meas_valid, 0);
        tick(1);
        check("steady1_mv",     a_if.meas_valid, 1);
        check("steady1_high",   a_if.high_time, 10);
        check("steady1_low",    a_if.low_time, 20);
        check("steady1_period", a_if.period, 30);
        tick(1);
        check("mv_one_cycle",   a_if.meas_valid, 0);
        drive(0, 1, 6);
        drive(0, 0, 20);
        a_if.sig_in = 1'b1;
        tick(3);
        check("steady2_mv",     a_if.meas_valid, 1);
        check("steady2_period", a_if.period, 30);

        // Start mid-high: partial phase at release is discarded
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        m0 = a_mv_cnt;
        drive(0, 1, 8);
        drive(0, 0, 15);
        drive(0, 1, 12);
        drive(0, 0, 7);
        a_if.sig_in = 1'b1;
        tick(2);
        check("midhigh_no_partial", a_mv_cnt, m0);
        tick(1);
        check("midhigh_mv",     a_if.meas_valid, 1);
        check("midhigh_high",   a_if.high_time, 12);
        check("midhigh_low",    a_if.low_time, 7);
        check("midhigh_period", a_if.period, 19);

        // Saturation on the 4-bit instance, then clear
        drive(1, 0, 4);
        drive(1, 1, 20);
        check("sat_ovf_set", b_if.ovf, 1);
        drive(1, 0, 5);
        b_if.sig_in = 1'b1;
        tick(3);
        check("sat_mv",     b_if.meas_valid, 1);
        check("sat_high",   b_if.high_time, 15);
        check("sat_low",    b_if.low_time, 5);
        check("sat_period", b_if.period, 20);
        check("sat_ovf",    b_if.ovf, 1);
        b_if.clr = 1'b1;
        tick(1);
        b_if.clr = 1'b0;
        check("clr_ovf",    b_if.ovf, 0);
        check("clr_high",   b_if.high_time, 0);
        check("clr_low",    b_if.low_time, 0);
        check("clr_period", b_if.period, 0);
        check("clr_mv",     b_if.meas_valid, 0);
        drive(1, 1, 3);
        drive(1, 0, 4);
        b_if.sig_in = 1'b1;
        tick(3);
        check("clr_wait_state", b_if.meas_valid, 0);
        drive(1, 1, 3);
        drive(1, 0, 5);
        b_if.sig_in = 1'b1;
        tick(3);
        check("postclr_mv",     b_if.meas_valid, 1);
        check("postclr_high",   b_if.high_time, 6);
        check("postclr_low",    b_if.low_time, 5);
        check("postclr_period", b_if.period, 11);
        check("postclr_ovf",    b_if.ovf, 0);
        b_if.sig_in = 1'b0;

        // Reset during the low phase
        drive(0, 0, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_high",   a_if.high_time, 0);
        check("midrst_low",    a_if.low_time, 0);
        check("midrst_period", a_if.period, 0);
        check("midrst_mv",     a_if.meas_valid, 0);
        m0 = a_mv_cnt;
        tick(3);
        rst_n = 1'b1;
        check("midrst_no_mv", a_mv_cnt, m0);
        drive(0, 0, 5);
        drive(0, 1, 10);
        drive(0, 0, 20);
        a_if.sig_in = 1'b1;
        tick(3);
        check("after_rst_mv",     a_if.meas_valid, 1);
        check("after_rst_high",   a_if.high_time, 10);
        check("after_rst_low",    a_if.low_time, 20);
        check("after_rst_period", a_if.period, 30);

        // Tolerance check: 11/19 within, 12/20 outside
        drive(0, 1, 8);
        drive(0, 0, 19);
        a_if.sig_in = 1'b1;
        tick(3);
        check("chk1_mv",    a_if.meas_valid, 1);
        check("chk1_high",  a_if.high_time, 11);
        check("chk1_low",   a_if.low_time, 19);
        check("chk1_match", a_if.match, exp_match);
        drive(0, 1, 9);
        drive(0, 0, 20);
        a_if.sig_in = 1'b1;
        tick(3);
        check("chk2_mv",    a_if.meas_valid, 1);
        check("chk2_high",  a_if.high_time, 12);
        check("chk2_low",   a_if.low_time, 20);
        check("chk2_match", a_if.match, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
